// File: rtl/run_ctrl_if.sv
// Button, halt and status bundle between the board/core side and the run/halt controller.
interface run_ctrl_if;
    logic       btn_run;
    logic       btn_step;
    logic       cpu_halt;
    logic       halting;
    logic       cpu_en;
    logic [1:0] state;

    modport master (
        output btn_run,
        output btn_step,
        output cpu_halt,
        input  halting,
        input  cpu_en,
        input  state
    );

    modport slave (
        input  btn_run,
        input  btn_step,
        input  cpu_halt,
        output halting,
        output cpu_en,
        output state
    );
endinterface

// File: rtl/run_ctrl.sv
// Run/step/halt controller: debounces RUN and STEP buttons and produces the core
// clock-enable plus the halting level for the display stage.
module run_ctrl #(
    parameter int DEBOUNCE     = 1000000,
    parameter int CNT_W        = 20,
    parameter bit RUN_ON_RESET = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    run_ctrl_if.slave  bus
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_STEP     = 2'd2;
    localparam logic [1:0] ST_CPU_HALT = 2'd3;

    localparam logic [1:0] RESET_STATE = RUN_ON_RESET ? ST_RUN : ST_IDLE;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    // Bit 0 is the RUN button, bit 1 the STEP button.
    logic [1:0]       raw_s;
    logic [1:0]       sync1_r;
    logic [1:0]       sync2_r;
    logic [1:0]       db_r;
    logic [1:0]       db_q_r;
    logic [CNT_W-1:0] cnt_r [2];
    logic [1:0]       press_s;

    logic [1:0]       state_r;
    logic [1:0]       next_state_s;
    logic             halting_r;
    logic             cpu_en_r;

    assign raw_s   = {bus.btn_step, bus.btn_run};
    assign press_s = db_r & ~db_q_r;

    // Two-flop synchroniser, debounce counter and edge register for each button.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r  <= 2'b00;
            sync2_r  <= 2'b00;
            db_r     <= 2'b00;
            db_q_r   <= 2'b00;
            cnt_r[0] <= '0;
            cnt_r[1] <= '0;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            db_q_r  <= db_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] == db_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] == CNT_MAX) begin
                    db_r[i]  <= sync2_r[i];
                    cnt_r[i] <= '0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Next-state selection; CPU_HALT is sticky until reset.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (press_s[0]) begin
                    next_state_s = ST_RUN;
                end else if (press_s[1]) begin
                    next_state_s = ST_STEP;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.cpu_halt) begin
                    next_state_s = ST_CPU_HALT;
                end else if (press_s[0]) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_STEP: begin
                if (bus.cpu_halt) begin
                    next_state_s = ST_CPU_HALT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_CPU_HALT: next_state_s = ST_CPU_HALT;
            default:     next_state_s = RESET_STATE;
        endcase
    end

    // Outputs are registered alongside the state so they track the state register exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= RESET_STATE;
            halting_r <= (RESET_STATE != ST_RUN);
            cpu_en_r  <= (RESET_STATE == ST_RUN) | (RESET_STATE == ST_STEP);
        end else begin
            state_r   <= next_state_s;
            halting_r <= (next_state_s != ST_RUN);
            cpu_en_r  <= (next_state_s == ST_RUN) | (next_state_s == ST_STEP);
        end
    end

    assign bus.state   = state_r;
    assign bus.halting = halting_r;
    assign bus.cpu_en  = cpu_en_r;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl with DEBOUNCE=4: expected per-cycle state is queued
// when stimulus is driven and compared at each falling edge.
module tb_run_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fails  = 0;

    typedef struct {
        int         cyc;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];

    run_ctrl_if bus ();

    run_ctrl #(
        .DEBOUNCE     (4),
        .CNT_W        (3),
        .RUN_ON_RESET (1'b0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, expv, cyc);
        end
    endtask

    // Queue expected state for cycles cyc+from_rel .. cyc+to_rel.
    task automatic expect_span(input int from_rel, input int to_rel, input logic [1:0] st);
        exp_t e;
        for (int i = from_rel; i <= to_rel; i++) begin
            e.cyc = cyc + i;
            e.st  = st;
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    // Compare DUT outputs against the queued expectation away from the rising edge.
    always @(negedge clock) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check_eq("state",   {30'd0, bus.state}, {30'd0, e.st});
            check_eq("halting", {31'd0, bus.halting}, {31'd0, (e.st != 2'd1)});
            check_eq("cpu_en",  {31'd0, bus.cpu_en},  {31'd0, (e.st == 2'd1) || (e.st == 2'd2)});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.btn_run  = 1'b0;
        bus.btn_step = 1'b0;
        bus.cpu_halt = 1'b0;
        reset        = 1'b1;
        step(3);
        reset = 1'b0;

        // Reset state with idle inputs.
        expect_span(1, 20, 2'd0);
        step(20);

        // RUN held: enters RUN 7 cycles after drive, stays while held and after release.
        expect_span(1, 6, 2'd0);
        expect_span(7, 40, 2'd1);
        bus.btn_run = 1'b1;
        step(30);
        bus.btn_run = 1'b0;
        step(10);
        // Second press returns to IDLE.
        expect_span(1, 6, 2'd1);
        expect_span(7, 20, 2'd0);
        bus.btn_run = 1'b1;
        step(8);
        bus.btn_run = 1'b0;
        step(12);

        // Glitch train shorter than the debounce window.
        expect_span(1, 25, 2'd0);
        bus.btn_run = 1'b1; step(3);
        bus.btn_run = 1'b0; step(1);
        bus.btn_run = 1'b1; step(2);
        bus.btn_run = 1'b0; step(19);

        // Single step: exactly one cycle in STEP.
        expect_span(1, 6, 2'd0);
        expect_span(7, 7, 2'd2);
        expect_span(8, 20, 2'd0);
        bus.btn_step = 1'b1; step(10);
        bus.btn_step = 1'b0; step(10);

        // Enter RUN, then halt coincident with a run press.
        expect_span(1, 6, 2'd0);
        expect_span(7, 20, 2'd1);
        bus.btn_run = 1'b1; step(8);
        bus.btn_run = 1'b0; step(12);
        expect_span(1, 6, 2'd1);
        expect_span(7, 40, 2'd3);
        expect_span(41, 45, 2'd0);
        bus.btn_run = 1'b1; step(6);
        bus.cpu_halt = 1'b1; step(1);
        bus.cpu_halt = 1'b0; step(3);
        bus.btn_run = 1'b0; step(5);
        bus.btn_step = 1'b1; step(10);
        bus.btn_step = 1'b0;
        bus.btn_run  = 1'b1; step(8);
        bus.btn_run  = 1'b0; step(7);
        reset = 1'b1; step(2);
        reset = 1'b0; step(3);

        // Simultaneous RUN and STEP: RUN wins, STEP never appears.
        expect_span(1, 6, 2'd0);
        expect_span(7, 20, 2'd1);
        bus.btn_run  = 1'b1;
        bus.btn_step = 1'b1;
        step(8);
        bus.btn_run  = 1'b0;
        bus.btn_step = 1'b0;
        step(12);

        // Reset during debounce of a second press discards it.
        expect_span(1, 3, 2'd1);
        expect_span(4, 20, 2'd0);
        bus.btn_run = 1'b1; step(3);
        bus.btn_run = 1'b0;
        reset = 1'b1; step(1);
        reset = 1'b0; step(16);

        step(2);
        check_eq("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
